// File: rtl/pc_stack_counter.sv
// Program counter: counts with wrap at LAST_ADDR, loads jumps from the shared W bus and drives
// it through a tri-state buffer. Define PC_STACK_EN to build the call/return address stack.
module pc_stack_counter #(
    parameter int WIDTH       = 4,
    parameter int LAST_ADDR   = 2**WIDTH-1,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk_n,
    input  logic             clr,
    input  logic             cp,
    input  logic             ep,
    input  logic             lp,
    input  logic             call,
    input  logic             ret,
    inout  wire  [WIDTH-1:0] w_bus,
    output logic [WIDTH-1:0] pc,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(LAST_ADDR);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_ADDR);
    localparam int               DW    = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] top;
    logic             ret_en;
    logic             call_en;
    logic             pop;
    logic             push;

    // Only an exact match on LAST wraps; values loaded above it roll over naturally.
    assign count_inc = (count == LAST) ? '0 : count + WIDTH'(1);
    assign pc        = count;
    assign w_bus     = ep ? count : {WIDTH{1'bz}};

`ifdef PC_STACK_EN
    logic [DW-1:0]                  depth;
    logic [2**DW-1:0][WIDTH-1:0]    stack_mem;

    assign ret_en    = ret;
    assign call_en   = call;
    assign stk_full  = (depth == DW'(STACK_DEPTH));
    assign stk_empty = (depth == '0);
    assign pop       = ret && !stk_empty;
    // A call while the bus is self-driven is a conflict, never a push.
    assign push      = !ret && call && !ep && !stk_full;
    assign top       = stack_mem[depth - DW'(1)];

    always_ff @(negedge clk_n or posedge clr) begin
        if (clr)
            depth <= '0;
        else if (pop)
            depth <= depth - DW'(1);
        else if (push)
            depth <= depth + DW'(1);
    end

    always_ff @(negedge clk_n) begin
        if (push)
            stack_mem[depth] <= count_inc;
    end
`else
    logic          unused_cmds;
    logic [DW-1:0] unused_depth;

    assign unused_cmds  = call ^ ret;
    assign unused_depth = '0;
    assign ret_en       = 1'b0;
    assign call_en      = 1'b0;
    assign stk_full     = 1'b0;
    assign stk_empty    = 1'b1;
    assign pop          = 1'b0;
    assign push         = 1'b0;
    assign top          = '0;
`endif

    // Priority: ret > call > lp > cp; only the winner acts.
    always_ff @(negedge clk_n or posedge clr) begin
        if (clr) begin
            count   <= RST_V;
            stk_err <= 1'b0;
        end else if (ret_en) begin
            if (pop) count <= top;
            else     stk_err <= 1'b1;
        end else if (call_en) begin
            if (push) count <= w_bus;
            else      stk_err <= 1'b1;
        end else if (lp) begin
            if (ep) stk_err <= 1'b1;
            else    count <= w_bus;
        end else if (cp) begin
            count <= count_inc;
        end
    end
endmodule
